// File: rtl/squat_cfg_pkg.sv
// Shared types for the SQUAT cell-config CPU bridge: config word layout, bus modes, FSM states.
package squat_cfg_pkg;

  localparam int VPI_W      = 12;
  localparam int NUM_TX_DEF = 4;

  typedef struct packed {
    logic [NUM_TX_DEF-1:0] fwd;
    logic [VPI_W-1:0]      vpi;
  } CellCfgType;

  typedef enum logic {
    MOTOROLA = 1'b0,
    INTEL    = 1'b1
  } bus_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EXEC,
    ACK
  } bridge_state_e;

endpackage

// File: rtl/cpu_strobe_sync.sv
// N-bit two-flop synchroniser; flops preset to 1 so active-low bus pins read as inactive out of reset.
module cpu_strobe_sync #(
  parameter int N = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] meta_q;
  logic [N-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cpu_cfg_bridge.sv
// CPU-bus slave (Intel/Motorola) in front of the per-VPI cell-config table, with a
// one-cycle datapath lookup port and a valid bitmap that masks the unreset RAM.
module cpu_cfg_bridge
  import squat_cfg_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 256,
  parameter int NUM_TX      = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    BusMode,
  input  logic [ADDR_W-1:0]       Addr,
  input  logic                    Sel,
  input  logic [NUM_TX+VPI_W-1:0] DataIn,
  output logic [NUM_TX+VPI_W-1:0] DataOut,
  input  logic                    Rd_DS,
  input  logic                    Wr_RW,
  output logic                    Rdy_Dtack,
  input  logic                    lkup_vld,
  input  logic [ADDR_W-1:0]       lkup_addr,
  output logic [NUM_TX+VPI_W-1:0] lkup_data,
  output logic                    lkup_hit,
  output logic                    err_addr
);

  localparam int CW    = NUM_TX + VPI_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [2:0]    pins_s;
  logic          sel_n_s, rd_n_s, wr_n_s;
  bridge_state_e state_q;
  bus_mode_e     mode_q, mode_cur;
  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0]     data_q, dout_q, lkup_data_q;
  logic              is_wr_q, rdy_q, err_q, lkup_hit_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DEPTH-1:0]  valid_q;
  logic [CW-1:0]     mem_q [DEPTH];
  logic              req, in_range, lk_in_range, wr_en;
  logic [IDX_W-1:0]  idx, lk_idx;

  cpu_strobe_sync #(.N(3)) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   ({Sel, Rd_DS, Wr_RW}),
    .q_o   (pins_s)
  );

  assign {sel_n_s, rd_n_s, wr_n_s} = pins_s;

  // Mode follows the pin only while idle; a transaction keeps the mode it started with.
  assign mode_cur = (state_q == IDLE) ? bus_mode_e'(BusMode) : mode_q;

  always_comb begin
    req = 1'b0;
    if (!sel_n_s)
      req = (mode_cur == INTEL) ? (!rd_n_s ^ !wr_n_s) : !rd_n_s;
  end

  assign in_range    = {1'b0, addr_q} < DEPTH_L;
  assign lk_in_range = {1'b0, lkup_addr} < DEPTH_L;
  assign idx         = addr_q[IDX_W-1:0];
  assign lk_idx      = lkup_addr[IDX_W-1:0];
  assign wr_en       = (state_q == EXEC) && is_wr_q && in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= INTEL;
      addr_q  <= '0;
      data_q  <= '0;
      is_wr_q <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= '0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          mode_q  <= bus_mode_e'(BusMode);
          addr_q  <= Addr;
          data_q  <= DataIn;
          is_wr_q <= !wr_n_s;
          cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
          state_q <= (WAIT_CYCLES == 0) ? EXEC : WAIT;
        end
        WAIT: begin
          if (sel_n_s)          state_q <= IDLE;
          else if (cnt_q == '0) state_q <= EXEC;
          else                  cnt_q   <= cnt_q - 1'b1;
        end
        EXEC: begin
          if (!in_range) begin
            dout_q <= '0;
            err_q  <= 1'b1;
          end else if (!is_wr_q) begin
            dout_q <= valid_q[idx] ? mem_q[idx] : '0;
          end
          rdy_q   <= 1'b0;
          state_q <= ACK;
        end
        ACK: if (!req) begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Table storage is deliberately unreset; valid_q masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid_q      <= '0;
    else if (wr_en) valid_q[idx] <= 1'b1;
  end

  // Lookup reads pre-edge state, so a coincident CPU write is seen on the next lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lkup_hit_q  <= 1'b0;
      lkup_data_q <= '0;
    end else if (lkup_vld) begin
      if (lk_in_range && valid_q[lk_idx]) begin
        lkup_hit_q  <= 1'b1;
        lkup_data_q <= mem_q[lk_idx];
      end else begin
        lkup_hit_q  <= 1'b0;
        lkup_data_q <= '0;
      end
    end
  end

  assign DataOut   = dout_q;
  assign Rdy_Dtack = rdy_q;
  assign err_addr  = err_q;
  assign lkup_hit  = lkup_hit_q;
  assign lkup_data = lkup_data_q;

endmodule

// File: tb/tb_cpu_cfg_bridge.sv
// Directed bench for cpu_cfg_bridge: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
// Latency is counted in rising edges after the first edge that samples the asserted strobe.
module tb_cpu_cfg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        BusMode, Sel, Sel0, Rd_DS, Wr_RW, lkup_vld;
  logic [11:0] Addr, lkup_addr;
  logic [15:0] DataIn;
  logic [15:0] DataOut, DataOut0, lkup_data, lkup_data0;
  logic        Rdy_Dtack, Rdy_Dtack0, lkup_hit, lkup_hit0, err_addr, err_addr0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_cfg_bridge #(.ADDR_W(12), .DEPTH(256), .NUM_TX(4), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .BusMode(BusMode), .Addr(Addr), .Sel(Sel), .DataIn(DataIn),
    .DataOut(DataOut), .Rd_DS(Rd_DS), .Wr_RW(Wr_RW), .Rdy_Dtack(Rdy_Dtack),
    .lkup_vld(lkup_vld), .lkup_addr(lkup_addr), .lkup_data(lkup_data),
    .lkup_hit(lkup_hit), .err_addr(err_addr)
  );

  cpu_cfg_bridge #(.ADDR_W(12), .DEPTH(256), .NUM_TX(4), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .BusMode(BusMode), .Addr(Addr), .Sel(Sel0), .DataIn(DataIn),
    .DataOut(DataOut0), .Rd_DS(Rd_DS), .Wr_RW(Wr_RW), .Rdy_Dtack(Rdy_Dtack0),
    .lkup_vld(lkup_vld), .lkup_addr(lkup_addr), .lkup_data(lkup_data0),
    .lkup_hit(lkup_hit0), .err_addr(err_addr0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_release(input bit d0, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if ((d0 ? Rdy_Dtack0 : Rdy_Dtack) === 1'b1) begin ok = 1'b1; break; end
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic cpu_access(input bit d0, input bit intel, input bit wr,
                            input logic [11:0] a, input logic [15:0] d,
                            output int lat, output logic [15:0] rdata);
    @(negedge clk);
    BusMode = intel; Addr = a; DataIn = d;
    if (intel) begin Rd_DS = wr; Wr_RW = !wr; end
    else       begin Rd_DS = 1'b0; Wr_RW = !wr; end
    if (d0) Sel0 = 1'b0; else Sel = 1'b0;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if ((d0 ? Rdy_Dtack0 : Rdy_Dtack) === 1'b0) begin lat = i; break; end
    end
    rdata = d0 ? DataOut0 : DataOut;
    @(negedge clk);
    Sel = 1'b1; Sel0 = 1'b1; Rd_DS = 1'b1; Wr_RW = 1'b1;
    wait_release(d0, "rdy_release");
  endtask

  task automatic lookup(input logic [11:0] a, output logic hit, output logic [15:0] data);
    @(negedge clk);
    lkup_vld = 1'b1; lkup_addr = a;
    @(posedge clk); #1;
    hit = lkup_hit; data = lkup_data;
    @(negedge clk);
    lkup_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [15:0] rd, ld;
    logic        hit;
    int          lows;

    rst = 1'b1; BusMode = 1'b1; Sel = 1'b1; Sel0 = 1'b1; Rd_DS = 1'b1; Wr_RW = 1'b1;
    Addr = '0; DataIn = '0; lkup_vld = 1'b0; lkup_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dataout", DataOut, 16'h0);
    check("rst_rdy", Rdy_Dtack, 1'b1);
    check("rst_lkup_data", lkup_data, 16'h0);
    check("rst_lkup_hit", lkup_hit, 1'b0);
    check("rst_err", err_addr, 1'b0);
    @(negedge clk) rst = 1'b0;

    // Intel write then read of 0x005 = {FWD=1010, VPI=0x123}
    cpu_access(0, 1, 1, 12'h005, {4'b1010, 12'h123}, lat, rd);
    check("t1_wr_lat", lat, 5);
    cpu_access(0, 1, 0, 12'h005, 16'h0, lat, rd);
    check("t1_rd_lat", lat, 5);
    check("t1_rd_data", rd, {4'b1010, 12'h123});

    // Never-written entry
    cpu_access(0, 1, 0, 12'h010, 16'h0, lat, rd);
    check("t3_rd_unwritten", rd, 16'h0);
    lookup(12'h010, hit, ld);
    check("t3_lk_hit", hit, 1'b0);
    check("t3_lk_data", ld, 16'h0);

    // Motorola write to 0x0FF, then lookup and hold
    cpu_access(0, 0, 1, 12'h0FF, {4'b0101, 12'h0FF}, lat, rd);
    check("t2_moto_wr_lat", lat, 5);
    lookup(12'h0FF, hit, ld);
    check("t2_lk_hit", hit, 1'b1);
    check("t2_lk_data", ld, {4'b0101, 12'h0FF});
    @(negedge clk) lkup_addr = 12'h010;
    @(posedge clk); #1;
    check("t2_lk_hold_data", lkup_data, {4'b0101, 12'h0FF});
    check("t2_lk_hold_hit", lkup_hit, 1'b1);
    cpu_access(0, 0, 0, 12'h0FF, 16'h0, lat, rd);
    check("t2_moto_rd_data", rd, {4'b0101, 12'h0FF});

    // Out-of-range address
    cpu_access(0, 1, 0, 12'h005, 16'h0, lat, rd);
    check("t4_pre_read", rd, 16'hA123);
    check("t4_err_before", err_addr, 1'b0);
    cpu_access(0, 1, 1, 12'h100, 16'h1234, lat, rd);
    check("t4_oor_wr_lat", lat, 5);
    check("t4_err_set", err_addr, 1'b1);
    cpu_access(0, 1, 0, 12'h100, 16'h0, lat, rd);
    check("t4_oor_rd_data", rd, 16'h0);
    lookup(12'h100, hit, ld);
    check("t4_lk_hit", hit, 1'b0);
    check("t4_lk_data", ld, 16'h0);
    cpu_access(0, 1, 1, 12'h006, 16'h2666, lat, rd);
    check("t4_err_sticky", err_addr, 1'b1);
    check("t4_err_lkup_no_flag_dut0", err_addr0, 1'b0);

    // Lookup coincident with the EXEC write of 0x007
    cpu_access(0, 1, 1, 12'h007, 16'h3777, lat, rd);
    @(negedge clk);
    BusMode = 1'b1; Addr = 12'h007; DataIn = 16'hF456; Rd_DS = 1'b1; Wr_RW = 1'b0; Sel = 1'b0;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    lkup_vld = 1'b1; lkup_addr = 12'h007;
    @(posedge clk); #1;
    check("t5_ack_same_edge", Rdy_Dtack, 1'b0);
    check("t5_lk_old_data", lkup_data, 16'h3777);
    check("t5_lk_old_hit", lkup_hit, 1'b1);
    @(posedge clk); #1;
    check("t5_lk_new_data", lkup_data, 16'hF456);
    @(negedge clk);
    lkup_vld = 1'b0; Sel = 1'b1; Rd_DS = 1'b1; Wr_RW = 1'b1;
    wait_release(0, "t5_rdy_release");

    // Zero-wait-state instance
    cpu_access(1, 1, 1, 12'h003, 16'h9ABC, lat, rd);
    check("t6_w0_wr_lat", lat, 3);
    cpu_access(1, 1, 0, 12'h003, 16'h0, lat, rd);
    check("t6_w0_rd_lat", lat, 3);
    check("t6_w0_rd_data", rd, 16'h9ABC);

    // Reset asserted while a write to 0x020 sits in WAIT
    @(negedge clk);
    BusMode = 1'b1; Addr = 12'h020; DataIn = 16'h1111; Rd_DS = 1'b1; Wr_RW = 1'b0; Sel = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check("t6_rst_rdy", Rdy_Dtack, 1'b1);
    check("t6_rst_err_clr", err_addr, 1'b0);
    @(negedge clk);
    Sel = 1'b1; Rd_DS = 1'b1; Wr_RW = 1'b1;
    @(negedge clk) rst = 1'b0;
    lookup(12'h020, hit, ld);
    check("t6_rst_wr_lost", hit, 1'b0);
    lookup(12'h005, hit, ld);
    check("t6_rst_bitmap_clr", hit, 1'b0);

    // Sel released while the write to 0x030 is in WAIT
    @(negedge clk);
    BusMode = 1'b1; Addr = 12'h030; DataIn = 16'h4030; Rd_DS = 1'b1; Wr_RW = 1'b0; Sel = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) Sel = 1'b1;
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (Rdy_Dtack !== 1'b1) lows++;
    end
    check("t6_sel_abort_noack", lows, 0);
    @(negedge clk);
    Rd_DS = 1'b1; Wr_RW = 1'b1;
    lookup(12'h030, hit, ld);
    check("t6_sel_abort_nowrite", hit, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
